// File: rtl/spi_slave_mode0.sv
// rtl/spi_slave_mode0.sv - SPI mode-0 slave with oversampled pins and one-word TX holding register
//
// Purpose: far-end SPI responder (CPOL=0, CPHA=0). The SPI pins are synchronized
// into clk and edge-detected; one WORD_SIZE-bit word moves in each direction per
// word period, with back-to-back words allowed inside one chip-select frame.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN (partial-word frame error strobe).
//
// Ports:
//   clk, reset_n             local clock (>= 4x sclk), async active-low reset
//   spi_sclk, spi_cs_n       serial clock (idles low) and active-low chip select
//   spi_mosi                 master-out data
//   spi_miso, spi_miso_oe    slave-out data and its pad output enable
//   tx_data/tx_valid/tx_ready  one-word TX holding register handshake
//   rx_data/rx_valid         last complete received word and its one-clk strobe
//   busy                     frame in progress
//   underrun                 one-clk strobe: word started with holding register empty
//   frame_err                one-clk strobe: CS released mid-word (0 unless macro defined)
module spi_slave_mode0 #(
    parameter int WORD_SIZE   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 underrun,
    output logic                 frame_err
);

    localparam int CNT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_cur, cs_cur, mosi_cur;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [WORD_SIZE-1:0]   hold, tx_shift, rx_shift;
    logic                   hold_full;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   word_done;
    logic                   word_start, bit_in, bit_out;

    // Sync flops reset to the idle pin levels so no edge is seen out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_cur;
            cs_prev   <= cs_cur;
        end
    end

    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign cs_cur    = cs_sync[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_cur & ~sclk_prev;
    assign sclk_fall = ~sclk_cur & sclk_prev;
    assign cs_rise   = cs_cur & ~cs_prev;
    assign cs_fall   = ~cs_cur & cs_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // CS release wins over any sclk activity seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        word_start  = 1'b0;
        bit_in      = 1'b0;
        bit_out     = 1'b0;
        busy        = 1'b0;
        spi_miso_oe = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    word_start = 1'b1;
                end
            end
            ACTIVE: begin
                busy        = 1'b1;
                spi_miso_oe = 1'b1;
                bit_in      = sclk_rise;
                // A counter of zero on a falling edge means a word just wrapped:
                // the first edge of every word in mode 0 is a rise.
                if (sclk_fall && bit_cnt == '0) word_start = 1'b1;
                else                            bit_out    = sclk_fall;
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) begin
            state_d    = IDLE;
            word_start = 1'b0;
            bit_in     = 1'b0;
            bit_out    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            word_done <= 1'b0;

            if (cs_rise) begin
                bit_cnt <= '0;
            end else if (bit_in) begin
                rx_shift  <= {rx_shift[WORD_SIZE-2:0], mosi_cur};
                bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                word_done <= (bit_cnt == LAST_BIT);
            end

            if (word_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            if (word_start) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift <= '0;
                    underrun <= 1'b1;
                end
            end else if (bit_out) begin
                tx_shift <= {tx_shift[WORD_SIZE-2:0], 1'b0};
            end

            // Only accepted while empty, so this never collides with a consume.
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign spi_miso = tx_shift[WORD_SIZE-1];
    assign tx_ready = ~hold_full;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_err_q <= 1'b0;
        else          frame_err_q <= cs_rise && (bit_cnt != '0);
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
